plb_bram_port_initiator: RTL and testbench

Master-side driver for one port of the team's 64-bit dual-port BRAM block; it is the opposite end of the BRAM_* port interface.
Accepts a valid/ready request stream of reads and writes, issues the BRAM port cycles, and handles the fixed BRAM read latency.
Returns read data on a valid/ready response stream, with credit-based flow control so that responses are never dropped.
Sits between a PLB-side slave/bus-interface FSM and BRAM port A or B.

---
 rtl/plb_bram_pkg.sv | 16 +
 rtl/plb_bram_rsp_fifo.sv | 54 +++++
 rtl/plb_bram_port_initiator.sv | 122 ++++++++++++
 tb/tb_plb_bram_port_initiator.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/plb_bram_pkg.sv
// Shared widths, types and address-alignment constant for the BRAM port initiator.
// Pure declarations: no latency, no flow control.
package plb_bram_pkg;

  localparam int C_PORT_DWIDTH = 64;
  localparam int C_NUM_WE      = C_PORT_DWIDTH / 8;
  localparam int C_PORT_AWIDTH = 32;

  // Clears the byte-within-doubleword bits, bits [29:31] in MSB-first numbering
  localparam logic [0:C_PORT_AWIDTH-1] ADDR_ALIGN_MASK = 32'hFFFF_FFF8;

  typedef logic [0:C_PORT_DWIDTH-1] data_t;
  typedef logic [0:C_NUM_WE-1]      be_t;
  typedef logic [0:C_PORT_AWIDTH-1] addr_t;

endpackage

// File: rtl/plb_bram_rsp_fifo.sv
// Read-response FIFO; push visible on pop_data the cycle after the write, head held in flops.
// No internal backpressure: the caller's credit scheme guarantees push never meets full.
module plb_bram_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);

endmodule

// File: rtl/plb_bram_port_initiator.sv
// Master driver for one 64-bit BRAM port: request accept -> BRAM cycle next clock, read data returned after latency+2.
// Req_Ready is credit based, so accepted reads always have FIFO space; Rsp_Ready stalls hold the response head.
module plb_bram_port_initiator #(
  parameter int C_MEMSIZE      = 'h4000,
  parameter int C_PORT_DWIDTH  = 64,
  parameter int C_PORT_AWIDTH  = 32,
  parameter int C_NUM_WE       = 8,
  parameter int C_READ_LATENCY = 1,
  parameter int C_RSP_DEPTH    = 4
) (
  input  logic                     BRAM_Clk,
  input  logic                     BRAM_Rst_n,
  input  logic                     Req_Valid,
  output logic                     Req_Ready,
  input  logic                     Req_Write,
  input  logic [0:C_PORT_AWIDTH-1] Req_Addr,
  input  logic [0:C_PORT_DWIDTH-1] Req_Data,
  input  logic [0:C_NUM_WE-1]      Req_BE,
  output logic                     Rsp_Valid,
  input  logic                     Rsp_Ready,
  output logic [0:C_PORT_DWIDTH-1] Rsp_Data,
  output logic                     BRAM_Clk_O,
  output logic                     BRAM_Rst,
  output logic                     BRAM_EN,
  output logic [0:C_NUM_WE-1]      BRAM_WEN,
  output logic [0:C_PORT_AWIDTH-1] BRAM_Addr,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Dout,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Din
);

  import plb_bram_pkg::*;

  localparam int          CW        = $clog2(C_RSP_DEPTH) + 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(C_RSP_DEPTH);
  localparam addr_t       ADDR_MASK = addr_t'(C_MEMSIZE - 1) & ADDR_ALIGN_MASK;

  logic                      req_rdy_q;
  logic                      acc;
  logic                      rd_acc;
  logic                      pop;
  logic                      push;
  logic [CW-1:0]             credits;
  logic [CW-1:0]             credits_next;
  logic                      rd_issue;
  logic [C_READ_LATENCY-1:0] rd_pipe;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CW-1:0]             fifo_count;
  addr_t                     addr_masked;
  be_t                       wen_next;

  assign BRAM_Clk_O  = BRAM_Clk;
  assign BRAM_Rst    = ~BRAM_Rst_n;
  assign Req_Ready   = req_rdy_q;
  assign Rsp_Valid   = ~fifo_empty;

  assign acc         = Req_Valid && req_rdy_q;
  assign rd_acc      = acc && !Req_Write;
  assign pop         = Rsp_Valid && Rsp_Ready;
  assign addr_masked = Req_Addr & ADDR_MASK;
  assign wen_next    = (acc && Req_Write) ? Req_BE : '0;

  // One credit per FIFO slot; an in-flight read holds its credit until popped
  always_comb begin
    credits_next = credits;
    if (rd_acc && !pop)      credits_next = credits - CW'(1);
    else if (!rd_acc && pop) credits_next = credits + CW'(1);
  end

  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_n) begin
    if (!BRAM_Rst_n) begin
      credits   <= CRED_MAX;
      req_rdy_q <= 1'b0;
      BRAM_EN   <= 1'b0;
      BRAM_WEN  <= '0;
      BRAM_Addr <= '0;
      BRAM_Dout <= '0;
      rd_issue  <= 1'b0;
    end else begin
      credits   <= credits_next;
      req_rdy_q <= (credits_next != '0);
      BRAM_EN   <= acc;
      BRAM_WEN  <= wen_next;
      rd_issue  <= rd_acc;
      if (acc)              BRAM_Addr <= addr_masked;
      if (acc && Req_Write) BRAM_Dout <= Req_Data;
    end
  end

  // rd_pipe[k] marks a read whose EN cycle was k+1 clocks ago; the last stage samples BRAM_Din
  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_n) begin
    if (!BRAM_Rst_n) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= rd_issue;
      for (int i = 1; i < C_READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign push = rd_pipe[C_READ_LATENCY-1];

  plb_bram_rsp_fifo #(
    .DEPTH (C_RSP_DEPTH),
    .WIDTH (C_PORT_DWIDTH)
  ) u_rsp_fifo (
    .clk       (BRAM_Clk),
    .rst_n     (BRAM_Rst_n),
    .push      (push),
    .push_data (BRAM_Din),
    .pop       (pop),
    .pop_data  (Rsp_Data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  a_no_overflow: assert property (@(posedge BRAM_Clk) disable iff (!BRAM_Rst_n)
    !(push && fifo_full));
  a_credit_bound: assert property (@(posedge BRAM_Clk) disable iff (!BRAM_Rst_n)
    ({1'b0, credits} + {1'b0, fifo_count}) <= {1'b0, CRED_MAX});

endmodule

// File: tb/tb_plb_bram_port_initiator.sv
// Directed bench for plb_bram_port_initiator with a behavioural BRAM and a response scoreboard.
module tb_plb_bram_port_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Req_Valid, Req_Ready, Req_Write;
  logic [0:31] Req_Addr;
  logic [0:63] Req_Data;
  logic [0:7]  Req_BE;
  logic        Rsp_Valid, Rsp_Ready;
  logic [0:63] Rsp_Data;
  logic        BRAM_Clk_O, BRAM_Rst, BRAM_EN;
  logic [0:7]  BRAM_WEN;
  logic [0:31] BRAM_Addr;
  logic [0:63] BRAM_Dout;
  logic [0:63] BRAM_Din;

  int vectors = 0;
  int fails   = 0;
  int outstanding = 0;
  int max_out = 0;
  int rsp_cnt = 0;
  bit done;
  logic [0:63] exp_q[$];
  logic [0:63] mon_exp;
  logic [0:63] mem [0:2047];

  localparam logic [63:0] DA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DB = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] DC = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] DD = 64'hA5A5_5A5A_0F0F_F0F0;
  logic [31:0] addrs [4] = '{32'h10, 32'h20, 32'h8, 32'h18};
  logic [63:0] datas [4] = '{DA, DB, DC, DD};

  always #5 clk = ~clk;

  plb_bram_port_initiator dut (
    .BRAM_Clk   (clk),
    .BRAM_Rst_n (rst_n),
    .Req_Valid  (Req_Valid),
    .Req_Ready  (Req_Ready),
    .Req_Write  (Req_Write),
    .Req_Addr   (Req_Addr),
    .Req_Data   (Req_Data),
    .Req_BE     (Req_BE),
    .Rsp_Valid  (Rsp_Valid),
    .Rsp_Ready  (Rsp_Ready),
    .Rsp_Data   (Rsp_Data),
    .BRAM_Clk_O (BRAM_Clk_O),
    .BRAM_Rst   (BRAM_Rst),
    .BRAM_EN    (BRAM_EN),
    .BRAM_WEN   (BRAM_WEN),
    .BRAM_Addr  (BRAM_Addr),
    .BRAM_Dout  (BRAM_Dout),
    .BRAM_Din   (BRAM_Din)
  );

  // Behavioural BRAM, read latency 1, read-before-write
  always @(posedge clk) begin
    if (BRAM_EN) begin
      BRAM_Din <= mem[BRAM_Addr[18:28]];
      for (int b = 0; b < 8; b++)
        if (BRAM_WEN[b]) mem[BRAM_Addr[18:28]][8*b +: 8] <= BRAM_Dout[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every response handshake is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (Req_Valid && Req_Ready && !Req_Write) outstanding++;
      if (Rsp_Valid && Rsp_Ready) begin
        outstanding--;
        rsp_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL rsp_extra: got %h required no response", Rsp_Data);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("rsp_data", Rsp_Data, mon_exp);
        end
      end
      if (outstanding > max_out) max_out = outstanding;
    end
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [63:0] d,
                      input logic [7:0] be, input logic [63:0] exp);
    int n;
    n = 0;
    Req_Valid = 1'b1; Req_Write = w; Req_Addr = a; Req_Data = d; Req_BE = be;
    @(negedge clk);
    while (!Req_Ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!Req_Ready) begin
      vectors++;
      fails++;
      $display("FAIL req_accept_timeout: Req_Ready=0 after %0d cycles, required 1", n);
      Req_Valid = 1'b0;
    end else begin
      @(posedge clk);
      if (!w) exp_q.push_back(exp);
      #1 Req_Valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_en"},   64'(BRAM_EN),   64'd0);
    chk({tag, "_wen"},  64'(BRAM_WEN),  64'd0);
    chk({tag, "_addr"}, 64'(BRAM_Addr), 64'd0);
    chk({tag, "_dout"}, BRAM_Dout,      64'd0);
    chk({tag, "_rspv"}, 64'(Rsp_Valid), 64'd0);
    chk({tag, "_rspd"}, Rsp_Data,       64'd0);
    chk({tag, "_rdy"},  64'(Req_Ready), 64'd0);
    chk({tag, "_brst"}, 64'(BRAM_Rst),  64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; Req_Valid = 1'b0; Req_Write = 1'b0; Req_Addr = '0;
    Req_Data = '0; Req_BE = '0; Rsp_Ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    chk("clk_fwd", 64'(BRAM_Clk_O), 64'(clk));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_release", 64'(Req_Ready), 64'd1);
    chk("brst_released", 64'(BRAM_Rst), 64'd0);
    @(posedge clk); #1;

    // Known contents, then full write/read with latency checks
    send(1'b1, 32'h20, 64'd0, 8'hFF, 64'd0);
    send(1'b1, 32'h18, DD, 8'hFF, 64'd0);
    send(1'b1, 32'h10, DA, 8'hFF, 64'd0);
    chk("wr_en", 64'(BRAM_EN), 64'd1);
    chk("wr_wen", 64'(BRAM_WEN), 64'hFF);
    chk("wr_addr", 64'(BRAM_Addr), 64'h10);
    chk("wr_dout", BRAM_Dout, DA);
    send(1'b0, 32'h10, 64'd0, 8'h00, DA);
    chk("rd_en", 64'(BRAM_EN), 64'd1);
    chk("rd_wen", 64'(BRAM_WEN), 64'd0);
    chk("rd_dout_hold", BRAM_Dout, DA);
    @(negedge clk);
    chk("rd_lat_t1", 64'(Rsp_Valid), 64'd0);
    @(negedge clk);
    chk("rd_lat_t2", 64'(Rsp_Valid), 64'd0);
    chk("idle_en", 64'(BRAM_EN), 64'd0);
    @(negedge clk);
    chk("rd_lat_t3", 64'(Rsp_Valid), 64'd1);
    @(posedge clk); #1;
    drain("drain_basic");

    send(1'b1, 32'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'd0);
    chk("pw_wen", 64'(BRAM_WEN), 64'h0F);
    chk("pw_addr", 64'(BRAM_Addr), 64'h20);
    send(1'b0, 32'h20, 64'd0, 8'h00, DB);
    drain("drain_partial");

    send(1'b1, 32'h4008, DC, 8'hFF, 64'd0);
    chk("mask_wrap_addr", 64'(BRAM_Addr), 64'h8);
    send(1'b0, 32'h13, 64'd0, 8'h00, DA);
    chk("mask_align_addr", 64'(BRAM_Addr), 64'h10);
    send(1'b0, 32'h8, 64'd0, 8'h00, DC);
    drain("drain_mask");

    send(1'b1, 32'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0);
    chk("be0_en", 64'(BRAM_EN), 64'd1);
    chk("be0_wen", 64'(BRAM_WEN), 64'd0);
    send(1'b0, 32'h18, 64'd0, 8'h00, DD);
    drain("drain_be0");

    // Credit exhaustion: four reads fill every slot, the fifth waits for pops
    Rsp_Ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, addrs[i], 64'd0, 8'h00, datas[i]);
    @(negedge clk);
    chk("credit_empty_rdy", 64'(Req_Ready), 64'd0);
    Req_Valid = 1'b1; Req_Write = 1'b0; Req_Addr = 32'h10;
    repeat (8) begin
      @(negedge clk);
      chk("stall_rdy", 64'(Req_Ready), 64'd0);
      chk("stall_rspv", 64'(Rsp_Valid), 64'd1);
      chk("stall_data", Rsp_Data, DA);
    end
    @(posedge clk); #1;
    Rsp_Ready = 1'b1;
    send(1'b0, 32'h10, 64'd0, 8'h00, DA);
    drain("drain_backpressure");

    // Back-to-back reads against a toggling consumer
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) send(1'b0, addrs[i % 4], 64'd0, 8'h00, datas[i % 4]);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 Rsp_Ready = ~Rsp_Ready;
        end
      end
    join
    Rsp_Ready = 1'b1;
    drain("drain_toggle");
    chk("rsp_total", 64'(rsp_cnt), 64'd22);
    chk("max_outstanding", 64'(max_out), 64'd4);

    // Reset with two reads in flight
    Rsp_Ready = 1'b0;
    send(1'b0, 32'h10, 64'd0, 8'h00, DA);
    send(1'b0, 32'h20, 64'd0, 8'h00, DB);
    rst_n = 1'b0;
    exp_q.delete();
    outstanding = 0;
    #1;
    chk_reset_outputs("midrst");
    Rsp_Ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_rdy_pre", 64'(Req_Ready), 64'd0);
    @(negedge clk);
    chk("midrst_rdy_post", 64'(Req_Ready), 64'd1);
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_rsp", 64'(Rsp_Valid), 64'd0);
    end
    chk("midrst_rsp_total", 64'(rsp_cnt), 64'd22);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
